// File: rtl/rl_ram_arb_pkg.sv
// rl_ram_arb_pkg: shared types and helpers for the arbitrated 1R1W RAM wrapper.
package rl_ram_arb_pkg;
  localparam int MAX_NPORTS = 8;
  typedef logic [$clog2(MAX_NPORTS)-1:0] port_idx_t;
  function automatic logic [63:0] be_all_ones(int dbits);
    return (64'd1 << ((dbits + 7) / 8)) - 64'd1;
  endfunction
endpackage

// File: rtl/rl_ram_1r1w.sv
// rl_ram_1r1w: generic byte-writable 1R1W RAM with 1-cycle read and optional write-to-read bypass.
module rl_ram_1r1w #(
  parameter int ABITS = 10,
  parameter int DBITS = 32,
  parameter TECHNOLOGY = "GENERIC",
  parameter INIT_FILE = "",
  parameter RW_CONTENTION = "BYPASS"
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [ABITS-1:0]         waddr_i,
  input  logic [DBITS-1:0]         din_i,
  input  logic [(DBITS+7)/8-1:0]   be_i,
  input  logic                     re_i,
  input  logic [ABITS-1:0]         raddr_i,
  output logic [DBITS-1:0]         dout_o
);
  localparam bit BYPASS = (RW_CONTENTION == "BYPASS");
  logic [DBITS-1:0] mem_q [2**ABITS];
  logic [DBITS-1:0] dout_q;
  always_ff @(posedge clk_i)
    if (we_i)
      for (int b = 0; b < DBITS; b++)
        if (be_i[b/8]) mem_q[waddr_i][b] <= din_i[b];
  // Bypass forwards the whole write word; partial-be merging is not supported here.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) dout_q <= '0;
    else if (re_i) dout_q <= (BYPASS && we_i && waddr_i == raddr_i) ? din_i : mem_q[raddr_i];
  assign dout_o = dout_q;
endmodule

// File: rtl/rl_rr_arbiter.sv
// rl_rr_arbiter: round-robin arbiter; pointer moves past the winner only when advance_i is set.
module rl_rr_arbiter
  import rl_ram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_o
);
  port_idx_t ptr_q, ptr_d, win;
  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gnt_o = '0;
    win = ptr_q;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[(int'(ptr_q) + i) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_q) + i) % N] = 1'b1;
        win = port_idx_t'((int'(ptr_q) + i) % N);
      end
    ptr_d = advance_i ? port_idx_t'((int'(win) + 1) % N) : ptr_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/rl_ram_1r1w_arb.sv
// rl_ram_1r1w_arb: shares one rl_ram_1r1w between NPORTS requesters with independent RR read/write arbiters.
// Define RL_RAM_ARB_RDREG_EN to register rd_rdata_o/rd_rvalid_o (read latency 2 instead of 1).
module rl_ram_1r1w_arb
  import rl_ram_arb_pkg::*;
#(
  parameter int ABITS = 10,
  parameter int DBITS = 32,
  parameter int NPORTS = 4,
  parameter TECHNOLOGY = "GENERIC",
  parameter INIT_FILE = ""
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NPORTS-1:0]                 wr_req_i,
  input  logic [NPORTS*ABITS-1:0]           wr_addr_i,
  input  logic [NPORTS*DBITS-1:0]           wr_data_i,
  input  logic [NPORTS*((DBITS+7)/8)-1:0]   wr_be_i,
  output logic [NPORTS-1:0]                 wr_gnt_o,
  input  logic [NPORTS-1:0]                 rd_req_i,
  input  logic [NPORTS*ABITS-1:0]           rd_addr_i,
  output logic [NPORTS-1:0]                 rd_gnt_o,
  output logic [NPORTS-1:0]                 rd_rvalid_o,
  output logic [DBITS-1:0]                  rd_rdata_o
);
  localparam int BW = (DBITS + 7) / 8;
  localparam logic [BW-1:0] BE_ALL = BW'(be_all_ones(DBITS));
  logic [NPORTS-1:0] wcand, rcand, rv_q;
  logic [ABITS-1:0] waddr, raddr;
  logic [DBITS-1:0] wdata, dout;
  logic [BW-1:0] wbe;
  logic hazard;
  rl_rr_arbiter #(.N(NPORTS)) u_wr_arb (.clk_i, .rst_i, .req_i(wr_req_i), .advance_i(|wr_gnt_o), .gnt_o(wcand));
  rl_rr_arbiter #(.N(NPORTS)) u_rd_arb (.clk_i, .rst_i, .req_i(rd_req_i), .advance_i(|rd_gnt_o), .gnt_o(rcand));
  // A partial write to the read address cannot be bypassed, so the read waits one cycle.
  always_comb begin
    waddr = '0;
    wdata = '0;
    wbe = '0;
    raddr = '0;
    for (int p = 0; p < NPORTS; p++) begin
      waddr |= {ABITS{wcand[p]}} & wr_addr_i[p*ABITS +: ABITS];
      wdata |= {DBITS{wcand[p]}} & wr_data_i[p*DBITS +: DBITS];
      wbe |= {BW{wcand[p]}} & wr_be_i[p*BW +: BW];
      raddr |= {ABITS{rcand[p]}} & rd_addr_i[p*ABITS +: ABITS];
    end
    hazard = (|wcand) && (raddr == waddr) && (wbe != BE_ALL);
    wr_gnt_o = rst_i ? '0 : wcand;
    rd_gnt_o = (rst_i || hazard) ? '0 : rcand;
  end
  rl_ram_1r1w #(
    .ABITS(ABITS), .DBITS(DBITS), .TECHNOLOGY(TECHNOLOGY), .INIT_FILE(INIT_FILE), .RW_CONTENTION("BYPASS")
  ) u_ram (
    .clk_i, .rst_ni(~rst_i), .we_i(|wr_gnt_o), .waddr_i(waddr), .din_i(wdata), .be_i(wbe),
    .re_i(|rd_gnt_o), .raddr_i(raddr), .dout_o(dout)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) rv_q <= '0;
    else rv_q <= rd_gnt_o;
`ifdef RL_RAM_ARB_RDREG_EN
  logic [NPORTS-1:0] rv2_q;
  logic [DBITS-1:0] rdata_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rv2_q <= '0;
      rdata_q <= '0;
    end else begin
      rv2_q <= rv_q;
      rdata_q <= dout;
    end
  assign rd_rvalid_o = rv2_q;
  assign rd_rdata_o = rdata_q;
`else
  assign rd_rvalid_o = rv_q;
  assign rd_rdata_o = dout;
`endif
endmodule
